// File: rtl/cnn_inference_sequencer.sv
// cnn_inference_sequencer
// Drives one CNN inference per crop. It starts the core, streams the crop
// buffer into the CNN input stream through a 2-entry skid FIFO, then captures
// the class-score word and holds it until the result path accepts it.
module cnn_inference_sequencer #(
   parameter int FP_TOTAL = 8,
   parameter int OUT_ROWS = 48,
   parameter int OUT_COLS = 48,
   parameter int NUM_OUT  = 5,
   parameter int TIMEOUT  = 2**20
) (
   input  logic                                  ap_clk,
   input  logic                                  ap_rst,
   input  logic                                  crop_valid,
   output logic                                  crop_ack,
   output logic                                  buf_rd_en,
   output logic [$clog2(OUT_ROWS*OUT_COLS)-1:0]  buf_rd_addr,
   input  logic [FP_TOTAL-1:0]                   buf_rd_data,
   output logic                                  cnn_ap_start,
   input  logic                                  cnn_ap_ready,
   output logic [FP_TOTAL-1:0]                   cnn_in_TDATA,
   output logic                                  cnn_in_TVALID,
   input  logic                                  cnn_in_TREADY,
   input  logic [NUM_OUT*FP_TOTAL-1:0]           cnn_out_TDATA,
   input  logic                                  cnn_out_TVALID,
   output logic                                  cnn_out_TREADY,
   output logic [NUM_OUT*FP_TOTAL-1:0]           res_data,
   output logic                                  res_valid,
   input  logic                                  res_ready,
   output logic                                  busy,
   output logic                                  timeout_err,
   output logic [31:0]                           crop_count
);

   localparam int NPIX = OUT_ROWS * OUT_COLS;
   localparam int AW   = $clog2(NPIX);
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   PIX_TOTAL = (AW+1)'(NPIX);
   localparam logic [AW:0]   PIX_LAST  = (AW+1)'(NPIX - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_WAIT_OUT,
      S_DELIVER
   } state_t;

   state_t              state;
   logic [AW:0]         rd_issued;
   logic [AW:0]         beats_sent;
   logic                rd_pending;
   logic [FP_TOTAL-1:0] skid_mem [2];
   logic                skid_wr_ptr;
   logic                skid_rd_ptr;
   logic [1:0]          skid_count;
   logic                stream_done;
   logic [TW-1:0]       wait_cnt;

   logic                streaming;
   logic                pop;
   logic                last_beat;
   logic                timeout_hit;
   logic [2:0]          occupancy;

   // Read issue, skid handshake and completion decode for the current cycle
   always_comb begin
      streaming      = (state == S_START) || (state == S_STREAM);
      cnn_in_TVALID  = (skid_count != 2'd0);
      cnn_in_TDATA   = skid_mem[skid_rd_ptr];
      pop            = cnn_in_TVALID && cnn_in_TREADY;
      occupancy      = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, pop};
      buf_rd_en      = streaming && (rd_issued < PIX_TOTAL) && (occupancy < 3'd2);
      buf_rd_addr    = rd_issued[AW-1:0];
      last_beat      = pop && (beats_sent == PIX_LAST);
      timeout_hit    = (state == S_WAIT_OUT) && !cnn_out_TVALID && (wait_cnt == WAIT_LAST);
      crop_ack       = last_beat || timeout_hit;
      cnn_out_TREADY = (state == S_WAIT_OUT);
      busy           = (state != S_IDLE);
   end

   // Crop sequencing: start handshake, stream completion, result capture and delivery
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state        <= S_IDLE;
         cnn_ap_start <= 1'b0;
         stream_done  <= 1'b0;
         wait_cnt     <= '0;
         res_data     <= '0;
         res_valid    <= 1'b0;
         timeout_err  <= 1'b0;
         crop_count   <= 32'd0;
      end else begin
         wait_cnt <= '0;
         case (state)
            S_IDLE: begin
               if (crop_valid) begin
                  state        <= S_START;
                  cnn_ap_start <= 1'b1;
                  stream_done  <= 1'b0;
               end
            end
            S_START: begin
               if (last_beat) begin
                  stream_done <= 1'b1;
               end
               if (cnn_ap_ready) begin
                  cnn_ap_start <= 1'b0;
                  state        <= (stream_done || last_beat) ? S_WAIT_OUT : S_STREAM;
               end
            end
            S_STREAM: begin
               if (last_beat) begin
                  state <= S_WAIT_OUT;
               end
            end
            S_WAIT_OUT: begin
               if (cnn_out_TVALID) begin
                  res_data  <= cnn_out_TDATA;
                  res_valid <= 1'b1;
                  state     <= S_DELIVER;
               end else if (timeout_hit) begin
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            S_DELIVER: begin
               if (res_ready) begin
                  res_valid  <= 1'b0;
                  crop_count <= crop_count + 32'd1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Read address counter and 2-entry skid FIFO catching the 1-cycle-late buffer data
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rd_issued   <= '0;
         beats_sent  <= '0;
         rd_pending  <= 1'b0;
         skid_wr_ptr <= 1'b0;
         skid_rd_ptr <= 1'b0;
         skid_count  <= 2'd0;
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
      end else if (state == S_IDLE) begin
         rd_issued   <= '0;
         beats_sent  <= '0;
         rd_pending  <= 1'b0;
         skid_wr_ptr <= 1'b0;
         skid_rd_ptr <= 1'b0;
         skid_count  <= 2'd0;
      end else begin
         rd_pending <= buf_rd_en;
         if (buf_rd_en) begin
            rd_issued <= rd_issued + (AW+1)'(1);
         end
         if (rd_pending) begin
            skid_mem[skid_wr_ptr] <= buf_rd_data;
            skid_wr_ptr           <= ~skid_wr_ptr;
         end
         if (pop) begin
            skid_rd_ptr <= ~skid_rd_ptr;
            beats_sent  <= beats_sent + (AW+1)'(1);
         end
         skid_count <= skid_count + {1'b0, rd_pending} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// tb_cnn_inference_sequencer
// Directed bench: a crop buffer model holding addr&0xFF, a CNN model with a
// delayed start handshake, optional random input back-pressure and a delayed
// class-score word, plus queue scoreboards for pixels and results.
module tb_cnn_inference_sequencer;

   localparam int NPIX = 48 * 48;
   localparam int AW   = $clog2(NPIX);

   logic              ap_clk;
   logic              ap_rst;
   logic              crop_valid;
   logic              crop_ack;
   logic              buf_rd_en;
   logic [AW-1:0]     buf_rd_addr;
   logic [7:0]        buf_rd_data;
   logic              cnn_ap_start;
   logic              cnn_ap_ready;
   logic [7:0]        cnn_in_TDATA;
   logic              cnn_in_TVALID;
   logic              cnn_in_TREADY;
   logic [39:0]       cnn_out_TDATA;
   logic              cnn_out_TVALID;
   logic              cnn_out_TREADY;
   logic [39:0]       res_data;
   logic              res_valid;
   logic              res_ready;
   logic              busy;
   logic              timeout_err;
   logic [31:0]       crop_count;

   cnn_inference_sequencer #(.TIMEOUT(1000)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .crop_valid(crop_valid), .crop_ack(crop_ack),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready),
      .cnn_in_TDATA(cnn_in_TDATA), .cnn_in_TVALID(cnn_in_TVALID), .cnn_in_TREADY(cnn_in_TREADY),
      .cnn_out_TDATA(cnn_out_TDATA), .cnn_out_TVALID(cnn_out_TVALID), .cnn_out_TREADY(cnn_out_TREADY),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .timeout_err(timeout_err), .crop_count(crop_count)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  pix_q [$];
   logic [39:0] res_q [$];
   logic [39:0] cnn_word_q [$];

   bit stall_mode = 0;
   bit out_en     = 1;

   int cyc = 0, leave_cyc = 0, first_v_cyc = -1, first_beat_cyc = 0, last_beat_cyc = 0;
   int beats_total = 0, crop_beats = 0, crop_beat = 0, start_hs = 0;
   int beat_err = 0, ack_err = 0, stall_err = 0, res_err = 0, res_pops = 0;
   int tready_cycles = 0, terr_early = 0, wait_acks = 0;
   bit was_busy = 0, stalled_prev = 0, hs = 0, last = 0;
   logic [7:0]  stall_data, exp_pix;
   logic [39:0] exp_res, last_res;

   int start_age, rx, delay;
   bit pend;

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   // Crop buffer: 1-cycle read latency, contents addr & 0xFF
   always @(posedge ap_clk) begin
      if (buf_rd_en) buf_rd_data <= buf_rd_addr[7:0];
   end

   // CNN model: start accepted after a short delay, optional random TREADY, scores after the last pixel
   always @(posedge ap_clk) begin
      if (ap_rst) begin
         cnn_ap_ready   <= 1'b0;
         start_age      <= 0;
         rx             <= 0;
         pend           <= 1'b0;
         delay          <= 0;
         cnn_out_TVALID <= 1'b0;
         cnn_out_TDATA  <= '0;
         cnn_in_TREADY  <= 1'b1;
      end else begin
         start_age     <= cnn_ap_start ? start_age + 1 : 0;
         cnn_ap_ready  <= cnn_ap_start && !cnn_ap_ready && (start_age >= 2);
         cnn_in_TREADY <= stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
         if (cnn_in_TVALID && cnn_in_TREADY) begin
            if (rx == NPIX - 1) begin
               rx <= 0;
               if (out_en) begin
                  pend  <= 1'b1;
                  delay <= 4;
               end
            end else begin
               rx <= rx + 1;
            end
         end
         if (pend) begin
            if (delay == 0) begin
               pend           <= 1'b0;
               cnn_out_TVALID <= 1'b1;
               if (cnn_word_q.size() > 0) cnn_out_TDATA <= cnn_word_q.pop_front();
               else cnn_out_TDATA <= '0;
            end else begin
               delay <= delay - 1;
            end
         end
         if (cnn_out_TVALID && cnn_out_TREADY) cnn_out_TVALID <= 1'b0;
      end
   end

   // Monitor on the falling edge: pixel and result scoreboards, stall stability, handshake counts
   always @(negedge ap_clk) begin
      cyc++;
      if (ap_rst) begin
         was_busy     = 0;
         stalled_prev = 0;
      end else begin
         if (busy && !was_busy) begin
            leave_cyc   = cyc;
            first_v_cyc = -1;
         end
         was_busy = busy;
         if (cnn_in_TVALID && first_v_cyc < 0) first_v_cyc = cyc;
         if (stalled_prev && (!cnn_in_TVALID || cnn_in_TDATA !== stall_data)) stall_err++;
         stalled_prev = cnn_in_TVALID && !cnn_in_TREADY;
         stall_data   = cnn_in_TDATA;
         if (cnn_ap_start && cnn_ap_ready) start_hs++;
         if (cnn_out_TREADY) begin
            tready_cycles++;
            if (timeout_err) terr_early++;
         end
         hs   = cnn_in_TVALID && cnn_in_TREADY;
         last = 0;
         if (hs) begin
            beats_total++;
            crop_beats++;
            if (crop_beat == 0) first_beat_cyc = cyc;
            crop_beat++;
            if (pix_q.size() == 0) beat_err++;
            else begin
               exp_pix = pix_q.pop_front();
               if (cnn_in_TDATA !== exp_pix) beat_err++;
            end
            if (crop_beat == NPIX) begin
               last          = 1;
               crop_beat     = 0;
               last_beat_cyc = cyc;
               if (!crop_ack) ack_err++;
            end
         end
         if (crop_ack) begin
            if (cnn_out_TREADY) wait_acks++;
            else if (!last) ack_err++;
         end
         if (res_valid && res_ready) begin
            res_pops++;
            last_res = res_data;
            if (res_q.size() == 0) res_err++;
            else begin
               exp_res = res_q.pop_front();
               if (res_data !== exp_res) res_err++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearStats();
      beat_err = 0; ack_err = 0; stall_err = 0; res_err = 0; res_pops = 0;
      crop_beats = 0; tready_cycles = 0; terr_early = 0; wait_acks = 0;
   endtask

   // Queue the expected pixels (and optionally a result), raise crop_valid, wait for the start
   task automatic applyStimulus(input logic [39:0] word, input bit with_result);
      int n;
      for (int i = 0; i < NPIX; i++) pix_q.push_back(8'(i));
      if (with_result) begin
         res_q.push_back(word);
         cnn_word_q.push_back(word);
      end
      crop_valid = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge ap_clk);
         n++;
      end
   endtask

   task automatic waitIdle(input string tag, input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge ap_clk);
         n++;
      end
      checkOutput({tag, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int n, hs0, base;
      logic [39:0] snap;
      int hold_err;
      ap_rst     = 1'b1;
      crop_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (3) @(negedge ap_clk);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_start", {63'd0, cnn_ap_start}, 64'd0);
      checkOutput("rst_rd_en", {63'd0, buf_rd_en}, 64'd0);
      checkOutput("rst_res_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("rst_out_tready", {63'd0, cnn_out_TREADY}, 64'd0);
      checkOutput("rst_count", {32'd0, crop_count}, 64'd0);
      ap_rst = 1'b0;
      @(negedge ap_clk);

      $display("[TB] test 1: full-rate crop");
      clearStats();
      applyStimulus(40'h0102030405, 1'b1);
      crop_valid = 1'b0;
      waitIdle("t1", 6000);
      checkOutput("t1_beats", 64'(crop_beats), 64'(NPIX));
      checkOutput("t1_pix_err", 64'(beat_err), 64'd0);
      checkOutput("t1_ack_err", 64'(ack_err), 64'd0);
      checkOutput("t1_first_valid_lat", 64'(first_v_cyc - leave_cyc), 64'd2);
      checkOutput("t1_burst_len", 64'(last_beat_cyc - first_beat_cyc + 1), 64'(NPIX));
      checkOutput("t1_res_data", {24'd0, last_res}, 64'h0102030405);
      checkOutput("t1_res_err", 64'(res_err), 64'd0);
      checkOutput("t1_count", {32'd0, crop_count}, 64'd1);
      checkOutput("t1_start_hs", 64'(start_hs), 64'd1);

      $display("[TB] test 2: random input back-pressure");
      clearStats();
      stall_mode = 1;
      applyStimulus(40'hA1B2C3D4E5, 1'b1);
      crop_valid = 1'b0;
      waitIdle("t2", 9000);
      stall_mode = 0;
      checkOutput("t2_beats", 64'(crop_beats), 64'(NPIX));
      checkOutput("t2_pix_err", 64'(beat_err), 64'd0);
      checkOutput("t2_stall_err", 64'(stall_err), 64'd0);
      checkOutput("t2_ack_err", 64'(ack_err), 64'd0);
      checkOutput("t2_res_pops", 64'(res_pops), 64'd1);
      checkOutput("t2_res_err", 64'(res_err), 64'd0);
      checkOutput("t2_count", {32'd0, crop_count}, 64'd2);

      $display("[TB] test 3: result back-pressure");
      clearStats();
      res_ready = 1'b0;
      applyStimulus(40'h5566778899, 1'b1);
      n = 0;
      while (!res_valid && n < 6000) begin
         @(negedge ap_clk);
         n++;
      end
      checkOutput("t3_res_valid", {63'd0, res_valid}, 64'd1);
      snap     = res_data;
      hs0      = start_hs;
      hold_err = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge ap_clk);
         if (res_valid !== 1'b1 || res_data !== snap || cnn_ap_start !== 1'b0) hold_err++;
      end
      checkOutput("t3_hold_err", 64'(hold_err), 64'd0);
      checkOutput("t3_res_data", {24'd0, res_data}, 64'h5566778899);
      checkOutput("t3_no_restart", 64'(start_hs - hs0), 64'd0);
      crop_valid = 1'b0;
      res_ready  = 1'b1;
      waitIdle("t3", 10);
      checkOutput("t3_res_err", 64'(res_err), 64'd0);
      checkOutput("t3_count", {32'd0, crop_count}, 64'd3);

      $display("[TB] test 4: output timeout");
      clearStats();
      out_en = 0;
      applyStimulus(40'd0, 1'b0);
      crop_valid = 1'b0;
      waitIdle("t4", 6000);
      out_en = 1;
      checkOutput("t4_beats", 64'(crop_beats), 64'(NPIX));
      checkOutput("t4_wait_cycles", 64'(tready_cycles), 64'd1000);
      checkOutput("t4_timeout_ack", 64'(wait_acks), 64'd1);
      checkOutput("t4_terr_not_early", 64'(terr_early), 64'd0);
      checkOutput("t4_timeout_err", {63'd0, timeout_err}, 64'd1);
      checkOutput("t4_res_pops", 64'(res_pops), 64'd0);
      checkOutput("t4_ack_err", 64'(ack_err), 64'd0);
      checkOutput("t4_count", {32'd0, crop_count}, 64'd3);

      $display("[TB] test 5: reset mid-crop");
      clearStats();
      base = beats_total;
      applyStimulus(40'h1122334455, 1'b1);
      n = 0;
      while (beats_total < base + 1000 && n < 3000) begin
         @(negedge ap_clk);
         n++;
      end
      ap_rst     = 1'b1;
      crop_valid = 1'b0;
      @(negedge ap_clk);
      checkOutput("t5_rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("t5_rst_tvalid", {63'd0, cnn_in_TVALID}, 64'd0);
      checkOutput("t5_rst_ack", {63'd0, crop_ack}, 64'd0);
      checkOutput("t5_rst_res_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("t5_rst_timeout_err", {63'd0, timeout_err}, 64'd0);
      checkOutput("t5_rst_count", {32'd0, crop_count}, 64'd0);
      checkOutput("t5_rst_rd_en", {63'd0, buf_rd_en}, 64'd0);
      ap_rst = 1'b0;
      pix_q.delete();
      res_q.delete();
      cnn_word_q.delete();
      crop_beat = 0;
      @(negedge ap_clk);
      clearStats();
      applyStimulus(40'h1122334455, 1'b1);
      crop_valid = 1'b0;
      waitIdle("t5", 6000);
      checkOutput("t5_beats", 64'(crop_beats), 64'(NPIX));
      checkOutput("t5_pix_err", 64'(beat_err), 64'd0);
      checkOutput("t5_res_err", 64'(res_err), 64'd0);
      checkOutput("t5_res_pops", 64'(res_pops), 64'd1);
      checkOutput("t5_count", {32'd0, crop_count}, 64'd1);

      $display("[TB] test 6: three back-to-back crops");
      clearStats();
      hs0 = start_hs;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NPIX; i++) pix_q.push_back(8'(i));
         res_q.push_back(40'hC0FFEE0000 + 40'(k));
         cnn_word_q.push_back(40'hC0FFEE0000 + 40'(k));
      end
      crop_valid = 1'b1;
      n = 0;
      while (start_hs < hs0 + 3 && n < 12000) begin
         @(negedge ap_clk);
         n++;
      end
      crop_valid = 1'b0;
      waitIdle("t6", 6000);
      checkOutput("t6_start_hs", 64'(start_hs - hs0), 64'd3);
      checkOutput("t6_beats", 64'(crop_beats), 64'(3 * NPIX));
      checkOutput("t6_pix_err", 64'(beat_err), 64'd0);
      checkOutput("t6_ack_err", 64'(ack_err), 64'd0);
      checkOutput("t6_res_pops", 64'(res_pops), 64'd3);
      checkOutput("t6_res_err", 64'(res_err), 64'd0);
      checkOutput("t6_count", {32'd0, crop_count}, 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
